boreal_adaptive_denorm: RTL and testbench

Inverse of the adaptive Z-score normalizer: reconstructs feature-scale values x = z·σ + μ from an 8-channel packed frame of normalized values. It sits on the decode side of the Boreal feature path and maps model outputs or predictions back into raw sensor units. Per-channel μ/σ are loaded through a write port, typically mirrored from the normalizer's running statistics. Channels are processed sequentially through one shared multiplier.

---
 rtl/boreal_adaptive_denorm.sv | 126 ++++++++++++
 tb/tb_boreal_adaptive_denorm.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/boreal_adaptive_denorm.sv
// Inverse Z-score stage: rebuilds raw-unit values x = z*sigma + mu for an 8-channel
// Q8.8 frame, one channel at a time through a single shared multiplier.
module boreal_adaptive_denorm #(
  parameter int          MU_W    = 32,
  parameter logic [15:0] SIG_RST = 16'h0100
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid,
  input  logic [127:0]    features_in,
  input  logic            stat_we,
  input  logic [2:0]      stat_addr,
  input  logic [MU_W-1:0] stat_mu,
  input  logic [15:0]     stat_sigma,
  output logic            stat_rdy,
  output logic            busy,
  output logic [127:0]    features_out,
  output logic [7:0]      sat_out,
  output logic            done
);

  typedef enum logic [2:0] {IDLE, MUL, ADD, SAT, PACK} state_t;

  state_t                 state;
  logic [2:0]             ch;
  logic signed [15:0]     frame [8];
  logic signed [MU_W-1:0] mu [8];
  logic [15:0]            sigma [8];
  logic [15:0]            res [8];
  logic [7:0]             res_sat;
  logic signed [31:0]     prod;
  logic signed [32:0]     acc;

  logic signed [31:0]     z_ext;
  logic signed [31:0]     s_ext;
  logic signed [31:0]     mul_full;
  logic signed [31:0]     prod_sh;
  logic signed [32:0]     prod_ext;
  logic signed [32:0]     mu_ext;
  logic signed [32:0]     r_full;

  // sigma is unsigned, so it enters the signed multiply zero-extended
  assign z_ext    = {{16{frame[ch][15]}}, frame[ch]};
  assign s_ext    = {16'd0, sigma[ch]};
  assign mul_full = z_ext * s_ext;
  assign prod_sh  = prod >>> 8;
  assign prod_ext = {prod_sh[31], prod_sh};
  assign mu_ext   = {{(33-MU_W){mu[ch][MU_W-1]}}, mu[ch]};
  assign r_full   = acc >>> 8;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      ch           <= 3'd0;
      prod         <= '0;
      acc          <= '0;
      res_sat      <= '0;
      features_out <= '0;
      sat_out      <= '0;
      done         <= 1'b0;
      busy         <= 1'b0;
      stat_rdy     <= 1'b1;
      for (int k = 0; k < 8; k++) begin
        frame[k] <= '0;
        mu[k]    <= '0;
        sigma[k] <= SIG_RST;
        res[k]   <= '0;
      end
    end else begin
      // stat_rdy is only high in IDLE, so a write never disturbs a frame in flight
      if (stat_we && stat_rdy) begin
        mu[stat_addr]    <= stat_mu;
        sigma[stat_addr] <= stat_sigma;
      end
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (valid) begin
            for (int k = 0; k < 8; k++) frame[k] <= features_in[16*k +: 16];
            ch       <= 3'd0;
            busy     <= 1'b1;
            stat_rdy <= 1'b0;
            state    <= MUL;
          end else begin
            busy     <= 1'b0;
            stat_rdy <= 1'b1;
          end
        end
        MUL: begin
          prod  <= mul_full;
          state <= ADD;
        end
        ADD: begin
          acc   <= prod_ext + mu_ext;
          state <= SAT;
        end
        SAT: begin
          if (r_full > 33'sd32767) begin
            res[ch]     <= 16'h7FFF;
            res_sat[ch] <= 1'b1;
          end else if (r_full < -33'sd32768) begin
            res[ch]     <= 16'h8000;
            res_sat[ch] <= 1'b1;
          end else begin
            res[ch]     <= r_full[15:0];
            res_sat[ch] <= 1'b0;
          end
          if (ch == 3'd7) begin
            state <= PACK;
          end else begin
            ch    <= ch + 3'd1;
            state <= MUL;
          end
        end
        PACK: begin
          for (int k = 0; k < 8; k++) features_out[16*k +: 16] <= res[k];
          sat_out <= res_sat;
          done    <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_boreal_adaptive_denorm.sv
// Directed bench for boreal_adaptive_denorm: expected frames come from an integer
// reference model over shadow copies of mu/sigma and are queued per accepted frame.
module tb_boreal_adaptive_denorm;

  logic         clk = 1'b0;
  logic         rst;
  logic         valid;
  logic [127:0] features_in;
  logic         stat_we;
  logic [2:0]   stat_addr;
  logic [31:0]  stat_mu;
  logic [15:0]  stat_sigma;
  logic         stat_rdy;
  logic         busy;
  logic [127:0] features_out;
  logic [7:0]   sat_out;
  logic         done;

  int           checks = 0;
  int           errors = 0;
  logic [135:0] exp_q[$];
  logic [31:0]  sh_mu [8];
  logic [15:0]  sh_sig [8];
  logic [15:0]  z [8];
  logic [127:0] held;
  int           cnt;

  always #5 clk = ~clk;

  boreal_adaptive_denorm dut (
    .clk(clk), .rst(rst), .valid(valid), .features_in(features_in),
    .stat_we(stat_we), .stat_addr(stat_addr), .stat_mu(stat_mu), .stat_sigma(stat_sigma),
    .stat_rdy(stat_rdy), .busy(busy), .features_out(features_out), .sat_out(sat_out),
    .done(done)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [135:0] obs, input logic [135:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [16:0] model(input logic [15:0] zz, input logic [31:0] m,
                                        input logic [15:0] s);
    longint p, a, r;
    p = longint'($signed(zz)) * longint'(s);
    a = (p >>> 8) + longint'($signed(m));
    r = a >>> 8;
    if (r > 32767) return {1'b1, 16'h7FFF};
    if (r < -32768) return {1'b1, 16'h8000};
    return {1'b0, r[15:0]};
  endfunction

  function automatic logic [135:0] expect_frame();
    logic [135:0] e;
    logic [16:0]  m;
    e = '0;
    for (int k = 0; k < 8; k++) begin
      m = model(z[k], sh_mu[k], sh_sig[k]);
      e[16*k +: 16] = m[15:0];
      e[128+k]      = m[16];
    end
    return e;
  endfunction

  function automatic logic [127:0] pack_z();
    logic [127:0] f;
    for (int k = 0; k < 8; k++) f[16*k +: 16] = z[k];
    return f;
  endfunction

  task automatic reset_shadow();
    for (int k = 0; k < 8; k++) begin
      sh_mu[k]  = 32'd0;
      sh_sig[k] = 16'h0100;
    end
  endtask

  task automatic clear_z();
    for (int k = 0; k < 8; k++) z[k] = 16'h0000;
  endtask

  task automatic write_stat(input int a, input logic [31:0] m, input logic [15:0] s);
    stat_we    = 1'b1;
    stat_addr  = 3'(a);
    stat_mu    = m;
    stat_sigma = s;
    sh_mu[a]   = m;
    sh_sig[a]  = s;
    @(negedge clk);
    stat_we = 1'b0;
  endtask

  // called at a negedge; returns at the negedge after the accepting edge
  task automatic send_frame();
    features_in = pack_z();
    valid       = 1'b1;
    exp_q.push_back(expect_frame());
    @(posedge clk);
    @(negedge clk);
    valid       = 1'b0;
    stat_we     = 1'b0;
    features_in = {$urandom(), $urandom(), $urandom(), $urandom()};
    check("busy_on_accept", 136'({busy, stat_rdy}), 136'(2'b10));
  endtask

  task automatic wait_done(input string tag, input int start_n);
    int n;
    logic [135:0] e;
    n = start_n;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, 136'(n), 136'(25));
    check({tag, "_busy_in_done"}, 136'(busy), 136'(1));
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(tag, {sat_out, features_out}, e);
    end
    held = features_out;
  endtask

  task automatic post_done(input string tag);
    @(negedge clk);
    check({tag, "_after_done"}, 136'({done, busy, stat_rdy}), 136'(3'b001));
    repeat (2) @(negedge clk);
    check({tag, "_hold"}, 136'(features_out), 136'(held));
  endtask

  task automatic count_done(input int cycles, output int c);
    c = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (done === 1'b1) c++;
    end
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; stat_we = 1'b0; stat_addr = 3'd0;
    stat_mu = 32'd0; stat_sigma = 16'd0; features_in = '0;
    reset_shadow();
    clear_z();
    repeat (2) @(negedge clk);
    check("reset_outputs", {features_out, sat_out}, 136'd0);
    check("reset_flags", 136'({done, busy, stat_rdy}), 136'(3'b001));
    rst = 1'b0;
    @(negedge clk);

    // identity stats
    z[0] = 16'h0300; z[7] = 16'hFD00;
    send_frame();
    wait_done("identity", 0);
    check("identity_ch0", 136'(features_out[15:0]), 136'(16'h0003));
    check("identity_ch7", 136'(features_out[127:112]), 136'(16'hFFFD));
    post_done("identity");

    // loaded stats on ch0
    write_stat(0, 32'h0000_6400, 16'h0200);
    clear_z();
    z[0] = 16'hFE80; z[4] = 16'h1234; z[6] = 16'h8000;
    send_frame();
    wait_done("loaded", 0);
    check("loaded_ch0", 136'({sat_out[0], features_out[15:0]}), 136'({1'b0, 16'h0061}));
    post_done("loaded");

    // saturation both directions
    write_stat(1, 32'h007F_FF00, 16'h0200);
    write_stat(2, 32'hFF80_0000, 16'h0100);
    clear_z();
    z[1] = 16'h0100; z[2] = 16'hFF00;
    send_frame();
    wait_done("saturate", 0);
    check("sat_pos", 136'({sat_out[1], features_out[31:16]}), 136'({1'b1, 16'h7FFF}));
    check("sat_neg", 136'({sat_out[2], features_out[47:32]}), 136'({1'b1, 16'h8000}));
    post_done("saturate");

    // valid and stat write while busy are both dropped
    clear_z();
    z[0] = 16'h0100;
    send_frame();
    repeat (4) @(negedge clk);
    check("stat_rdy_busy", 136'(stat_rdy), 136'(0));
    valid = 1'b1; stat_we = 1'b1; stat_addr = 3'd0; stat_mu = 32'd0; stat_sigma = 16'h0200;
    features_in = {$urandom(), $urandom(), $urandom(), $urandom()};
    @(negedge clk);
    valid = 1'b0; stat_we = 1'b0;
    wait_done("busy_rules", 5);
    check("busy_rules_ch0", 136'(features_out[15:0]), 136'(16'd102));
    // back-to-back frame sampled at T0+26
    z[0] = 16'h0100; z[5] = 16'hF000;
    send_frame();
    wait_done("back_to_back", 0);
    check("b2b_ch0_mu_kept", 136'(features_out[15:0]), 136'(16'd102));
    post_done("back_to_back");
    count_done(30, cnt);
    check("no_extra_done", 136'(cnt), 136'(0));

    // stat write alongside valid in IDLE
    clear_z();
    z[3] = 16'h0100;
    stat_we = 1'b1; stat_addr = 3'd3; stat_mu = 32'd0; stat_sigma = 16'h0400;
    sh_mu[3] = 32'd0; sh_sig[3] = 16'h0400;
    send_frame();
    wait_done("write_with_valid", 0);
    check("wv_ch3", 136'(features_out[63:48]), 136'(16'd4));
    post_done("write_with_valid");

    // sigma = 0 yields mu >>> 8, including a negative mu rounding down
    write_stat(4, 32'h0001_2345, 16'h0000);
    write_stat(5, 32'hFFFF_FE80, 16'h0000);
    clear_z();
    z[4] = 16'h7FFF; z[5] = 16'h8000;
    send_frame();
    wait_done("sigma_zero", 0);
    check("sz_ch4", 136'(features_out[79:64]), 136'(16'h0123));
    check("sz_ch5", 136'(features_out[95:80]), 136'(16'hFFFE));
    post_done("sigma_zero");

    // random stats and frames
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++)
        write_stat($urandom_range(0, 7), 32'($urandom_range(0, 32'h00FF_FFFF)) - 32'h0080_0000,
                   16'($urandom_range(0, 16'h0400)));
      for (int k = 0; k < 8; k++) z[k] = 16'($urandom_range(0, 16'hFFFF));
      send_frame();
      wait_done("random", 0);
      post_done("random");
    end

    // reset in the middle of a frame
    clear_z();
    z[0] = 16'h0300;
    send_frame();
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midreset_outputs", {features_out, sat_out}, 136'd0);
    check("midreset_flags", 136'({done, busy, stat_rdy}), 136'(3'b001));
    @(negedge clk);
    rst = 1'b0;
    void'(exp_q.pop_front());
    reset_shadow();
    count_done(30, cnt);
    check("midreset_no_done", 136'(cnt), 136'(0));
    clear_z();
    z[0] = 16'h0300; z[3] = 16'h0100; z[4] = 16'h0200; z[7] = 16'hFD00;
    send_frame();
    wait_done("after_reset", 0);
    check("after_reset_ch3", 136'(features_out[63:48]), 136'(16'd1));
    post_done("after_reset");

    check("queue_empty", 136'(exp_q.size()), 136'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
